outport_pkt_sched: RTL and testbench

//  Packet-level scheduler for one router output port. It shares the output mux among

---
 rtl/noc_sched_pkg.sv | 13 +
 rtl/outport_pkt_sched_rr_pick.sv | 19 +
 rtl/outport_pkt_sched.sv | 66 ++++++
 tb/tb_outport_pkt_sched.sv | 127 ++++++++++++
 4 files changed

// File: rtl/noc_sched_pkg.sv
// noc_sched_pkg: shared scheduler types, defaults and a one-hot to index helper
package noc_sched_pkg;
    localparam int N_IN_DEF = 5;
    localparam int PTRW = $clog2(N_IN_DEF);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
    function automatic logic [PTRW-1:0] oh2idx(input logic [N_IN_DEF-1:0] oh);
        logic [PTRW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_IN_DEF; i++)
            if (oh[i]) idx |= PTRW'(i);
        return idx;
    endfunction
endpackage

// File: rtl/outport_pkt_sched_rr_pick.sv
// rr_pick: round-robin winner, first requester strictly after ptr, as one-hot
module rr_pick #(
    parameter int N_IN = 5,
    parameter int PW = 3
) (
    input  logic [N_IN-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [N_IN-1:0] win,
    output logic            valid
);
    logic [N_IN-1:0] hi_mask;
    logic [2*N_IN-1:0] dbl, first;
    // lower half holds requesters above ptr, upper half the wrapped full set
    assign hi_mask = {N_IN{1'b1}} << (ptr + PW'(1));
    assign dbl = {req, req & hi_mask};
    assign first = dbl & (~dbl + (2*N_IN)'(1));
    assign win = first[N_IN-1:0] | first[2*N_IN-1:N_IN];
    assign valid = |req;
endmodule

// File: rtl/outport_pkt_sched.sv
// outport_pkt_sched: packet-level round-robin output port scheduler with credit gating
module outport_pkt_sched
    import noc_sched_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int DEPTH = 4,
    parameter int CNTW = 3
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [N_IN-1:0] req,
    input  logic [N_IN-1:0] tail,
    input  logic            credit_in,
    output logic [N_IN-1:0] grt,
    output logic [N_IN-1:0] sel,
    output logic            fire,
    output logic [CNTW-1:0] credit_cnt,
    output logic            busy,
    output logic            err_ovf
);
    state_t state;
    logic [PTRW-1:0] ptr;
    logic [N_IN-1:0] win;
    logic win_valid, has_credit, owner_tail, ovf_hit;
    logic [CNTW:0] cnt_sum;
    logic [CNTW-1:0] cnt_next;
    rr_pick #(.N_IN(N_IN), .PW(PTRW)) u_pick (
        .req(req),
        .ptr(ptr),
        .win(win),
        .valid(win_valid)
    );
    assign has_credit = credit_cnt != '0;
    assign fire = |(req & grt) & has_credit;
    assign owner_tail = |(tail & grt);
    assign busy = state == S_BUSY;
    assign sel = grt;
    // one extra bit so a return at DEPTH is seen before saturating
    assign cnt_sum = {1'b0, credit_cnt} - (CNTW+1)'(fire) + (CNTW+1)'(credit_in);
    assign cnt_next = cnt_sum > (CNTW+1)'(DEPTH) ? CNTW'(DEPTH) : cnt_sum[CNTW-1:0];
    assign ovf_hit = credit_in & ~fire & (credit_cnt == CNTW'(DEPTH));
    always_ff @(posedge clk) begin
        if (rst_) begin
            state <= S_IDLE;
            grt <= '0;
            ptr <= PTRW'(N_IN - 1);
            credit_cnt <= CNTW'(DEPTH);
            err_ovf <= 1'b0;
        end else begin
            credit_cnt <= cnt_next;
            err_ovf <= err_ovf | ovf_hit;
            if (state == S_IDLE) begin
                if (win_valid && has_credit) begin
                    grt <= win;
                    state <= S_BUSY;
                end
            end else if (fire && owner_tail) begin
                grt <= '0;
                ptr <= oh2idx(grt);
                state <= S_IDLE;
            end
        end
    end
    a_onehot: assert property (@(posedge clk) disable iff (rst_) $onehot0(grt));
    a_fire_owner: assert property (@(posedge clk) disable iff (rst_) fire |-> grt != '0);
endmodule

// File: tb/tb_outport_pkt_sched.sv
// tb_outport_pkt_sched: scoreboard bench, per-cycle expected fire/grt/sel/cnt queue
module tb_outport_pkt_sched;
    logic clk = 1'b0;
    logic rst_;
    logic [4:0] req, tail, grt, sel;
    logic credit_in, fire, busy, err_ovf;
    logic [2:0] credit_cnt;
    int checks = 0;
    int errors = 0;
    logic [13:0] sb[$];
    always #5 clk = ~clk;
    outport_pkt_sched dut (
        .clk(clk),
        .rst_(rst_),
        .req(req),
        .tail(tail),
        .credit_in(credit_in),
        .grt(grt),
        .sel(sel),
        .fire(fire),
        .credit_cnt(credit_cnt),
        .busy(busy),
        .err_ovf(err_ovf)
    );
    always @(negedge clk) begin
        logic [13:0] e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({fire, grt, sel, credit_cnt} !== e) begin
                errors++;
                $display("FAIL cycle fire/grt/sel/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                    fire, grt, sel, credit_cnt, e[13], e[12:8], e[7:3], e[2:0]);
            end
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask
    task automatic cyc(input logic [4:0] r, input logic [4:0] t, input logic c,
                       input logic f, input logic [4:0] g, input logic [2:0] n);
        req = r;
        tail = t;
        credit_in = c;
        sb.push_back({f, g, g, n});
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst_ = 1'b1;
        req = '0;
        tail = '0;
        credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b0;
        chk("rst_grt", grt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", credit_cnt, 4);
        chk("rst_err", err_ovf, 0);
        // two single-flit packets, round-robin 1 then 2
        cyc(5'b00110, 5'b00110, 0, 0, 5'b00000, 4);
        cyc(5'b00110, 5'b00110, 0, 1, 5'b00010, 4);
        cyc(5'b00100, 5'b00100, 0, 0, 5'b00000, 3);
        cyc(5'b00100, 5'b00100, 0, 1, 5'b00100, 3);
        cyc(5'b00000, 5'b00000, 1, 0, 5'b00000, 2);
        cyc(5'b00000, 5'b00000, 1, 0, 5'b00000, 3);
        // 3-flit packet from input 3 with inputs 0/1 competing
        cyc(5'b01011, 5'b00000, 0, 0, 5'b00000, 4);
        cyc(5'b01011, 5'b00000, 0, 1, 5'b01000, 4);
        cyc(5'b01011, 5'b00000, 0, 1, 5'b01000, 3);
        cyc(5'b01011, 5'b01000, 0, 1, 5'b01000, 2);
        chk("gap_busy", busy, 0);
        cyc(5'b11011, 5'b00000, 1, 0, 5'b00000, 1);
        cyc(5'b10000, 5'b10000, 1, 1, 5'b10000, 2);
        cyc(5'b00000, 5'b00000, 1, 0, 5'b00000, 2);
        cyc(5'b00000, 5'b00000, 1, 0, 5'b00000, 3);
        chk("pre_ovf_err", err_ovf, 0);
        cyc(5'b00000, 5'b00000, 1, 0, 5'b00000, 4);
        chk("ovf_err", err_ovf, 1);
        chk("ovf_cnt", credit_cnt, 4);
        // 6-flit packet, credits run dry
        cyc(5'b00001, 5'b00000, 0, 0, 5'b00000, 4);
        cyc(5'b00001, 5'b00000, 0, 1, 5'b00001, 4);
        cyc(5'b00001, 5'b00000, 0, 1, 5'b00001, 3);
        cyc(5'b00001, 5'b00000, 0, 1, 5'b00001, 2);
        cyc(5'b00001, 5'b00000, 0, 1, 5'b00001, 1);
        cyc(5'b00001, 5'b00000, 0, 0, 5'b00001, 0);
        cyc(5'b00001, 5'b00000, 0, 0, 5'b00001, 0);
        cyc(5'b00001, 5'b00000, 1, 0, 5'b00001, 0);
        cyc(5'b00001, 5'b00000, 0, 1, 5'b00001, 1);
        cyc(5'b00001, 5'b00001, 1, 0, 5'b00001, 0);
        cyc(5'b00001, 5'b00001, 0, 1, 5'b00001, 1);
        cyc(5'b00000, 5'b00000, 1, 0, 5'b00000, 0);
        cyc(5'b00000, 5'b00000, 1, 0, 5'b00000, 1);
        cyc(5'b00000, 5'b00000, 1, 0, 5'b00000, 2);
        chk("sticky_err", err_ovf, 1);
        // bubble: owner 2 drops req for 2 cycles while others request
        cyc(5'b00100, 5'b00000, 0, 0, 5'b00000, 3);
        cyc(5'b00100, 5'b00000, 0, 1, 5'b00100, 3);
        cyc(5'b11011, 5'b00000, 0, 0, 5'b00100, 2);
        cyc(5'b11011, 5'b00000, 0, 0, 5'b00100, 2);
        chk("bubble_busy", busy, 1);
        cyc(5'b00100, 5'b00100, 0, 1, 5'b00100, 2);
        // reset mid-packet at cnt=1
        cyc(5'b00010, 5'b00000, 0, 0, 5'b00000, 1);
        rst_ = 1'b1;
        cyc(5'b00010, 5'b00000, 0, 1, 5'b00010, 1);
        rst_ = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grt", grt, 0);
        chk("mid_rst_cnt", credit_cnt, 4);
        chk("mid_rst_err", err_ovf, 0);
        cyc(5'b11111, 5'b00000, 0, 0, 5'b00000, 4);
        cyc(5'b11111, 5'b00001, 0, 1, 5'b00001, 4);
        cyc(5'b00000, 5'b00000, 0, 0, 5'b00000, 3);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
